cpu_core: RTL and testbench

CPU_CORE -- requirements
Module: cpu_core

---
 rtl/cpu_core.sv | 215 +++++++++++++++++++++
 tb/tb_cpu_core.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
// cpu_core: multi-cycle MIPS-I subset core with a single shared memory bus.
//
// Ports
//   clk           : sole clock, all state changes on the rising edge
//   res           : synchronous active-high reset
//   db_addr       : byte address of the current bus request (bits [1:0] always 0)
//   db_dataOut    : store data, meaningful while db_accessType is W
//   db_dataIn     : read/fetch data, sampled at the end of the cycle after a transfer
//   db_accessType : 00 NONE, 01 R (data read), 10 W (data write), 11 X (fetch)
//   db_ready      : memory accepts the presented request this cycle
//
// Bus handshake: a request (db_accessType != NONE) is transferred on a rising
// edge where db_ready=1. Until then addr/data/type are held unchanged. The
// cycle after a transfer always shows NONE, and read data for R/X is taken
// from db_dataIn at the end of that cycle.
//
// Instruction flow: FETCH (X@PC) -> IWAIT (latch IR) -> EXEC, then either
// back to FETCH, or MEM (R/W) -> MWAIT -> FETCH for LW/SW. All bus outputs
// are registers, loaded on the edge that enters the presenting state.
module cpu_core (
    input  logic        clk,
    input  logic        res,
    output logic [31:0] db_addr,
    output logic [31:0] db_dataOut,
    input  logic [31:0] db_dataIn,
    output logic [1:0]  db_accessType,
    input  logic        db_ready
);

    localparam logic [1:0] ACC_NONE = 2'b00;
    localparam logic [1:0] ACC_R    = 2'b01;
    localparam logic [1:0] ACC_W    = 2'b10;
    localparam logic [1:0] ACC_X    = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_IWAIT = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_MWAIT = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] dout_q, dout_d;
    logic [1:0]  acc_q, acc_d;
    logic [31:0] regs_q [32];

    // register file write port, resolved in the combinational block
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    // instruction fields
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [31:0] rs_val, rt_val;
    logic [31:0] pc_plus4;
    logic [31:0] eff_addr;
    logic        xfer;

    assign op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign rs_val   = (rs == 5'd0) ? 32'd0 : regs_q[rs];
    assign rt_val   = (rt == 5'd0) ? 32'd0 : regs_q[rt];
    assign pc_plus4 = pc_q + 32'd4;
    assign eff_addr = rs_val + imm_sext;
    assign xfer     = (acc_q != ACC_NONE) && db_ready;

    assign db_addr       = addr_q;
    assign db_dataOut    = dout_q;
    assign db_accessType = acc_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        acc_d    = acc_q;
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;

        case (state_q)
            S_FETCH: begin
                if (acc_q == ACC_NONE) begin
                    // only reached straight after reset: raise the first fetch
                    acc_d  = ACC_X;
                    addr_d = pc_q;
                end else if (xfer) begin
                    acc_d   = ACC_NONE;
                    state_d = S_IWAIT;
                end
            end

            S_IWAIT: begin
                ir_d    = db_dataIn;
                state_d = S_EXEC;
            end

            S_EXEC: begin
                pc_d = pc_plus4;
                case (op)
                    OP_RTYPE: begin
                        rf_waddr = rd;
                        case (funct)
                            FN_ADD: begin rf_we = 1'b1; rf_wdata = rs_val + rt_val; end
                            FN_SUB: begin rf_we = 1'b1; rf_wdata = rs_val - rt_val; end
                            FN_AND: begin rf_we = 1'b1; rf_wdata = rs_val & rt_val; end
                            FN_OR:  begin rf_we = 1'b1; rf_wdata = rs_val | rt_val; end
                            FN_SLT: begin
                                rf_we    = 1'b1;
                                rf_wdata = ($signed(rs_val) < $signed(rt_val)) ? 32'd1 : 32'd0;
                            end
                            default: rf_we = 1'b0;
                        endcase
                    end
                    OP_ADDI: begin
                        rf_we    = 1'b1;
                        rf_waddr = rt;
                        rf_wdata = rs_val + imm_sext;
                    end
                    OP_BEQ: if (rs_val == rt_val) pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
                    OP_BNE: if (rs_val != rt_val) pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
                    OP_J:   pc_d = {pc_plus4[31:28], ir_q[25:0], 2'b00};
                    default: ;
                endcase

                if (op == OP_LW || op == OP_SW) begin
                    state_d = S_MEM;
                    addr_d  = {eff_addr[31:2], 2'b00};
                    if (op == OP_SW) begin
                        acc_d  = ACC_W;
                        dout_d = rt_val;
                    end else begin
                        acc_d = ACC_R;
                    end
                end else begin
                    // next fetch is presented directly from EXEC: 3 cycles/instr
                    state_d = S_FETCH;
                    acc_d   = ACC_X;
                    addr_d  = pc_d;
                end
            end

            S_MEM: begin
                if (xfer) begin
                    acc_d   = ACC_NONE;
                    state_d = S_MWAIT;
                end
            end

            S_MWAIT: begin
                if (op == OP_LW) begin
                    rf_we    = 1'b1;
                    rf_waddr = rt;
                    rf_wdata = db_dataIn;
                end
                state_d = S_FETCH;
                acc_d   = ACC_X;
                addr_d  = pc_q;
            end

            default: begin
                state_d = S_FETCH;
                acc_d   = ACC_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= S_FETCH;
            pc_q    <= 32'd0;
            ir_q    <= 32'd0;
            addr_q  <= 32'd0;
            dout_q  <= 32'd0;
            acc_q   <= ACC_NONE;
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            acc_q   <= acc_d;
            // $0 stays zero: writes to it are dropped here
            if (rf_we && rf_waddr != 5'd0) regs_q[rf_waddr] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Testbench for cpu_core: bus memory model, instruction-level reference
// model feeding an expected-transfer queue, and a monitor that checks every
// bus transfer plus request stability during stalls.
module tb_cpu_core;

  localparam logic [1:0] A_NONE = 2'b00;
  localparam logic [1:0] A_R    = 2'b01;
  localparam logic [1:0] A_W    = 2'b10;
  localparam logic [1:0] A_X    = 2'b11;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic [31:0] db_addr, db_dataOut;
  logic [31:0] db_dataIn = 32'd0;
  logic [1:0]  db_accessType;
  logic        db_ready = 1'b1;

  always #5 clk = ~clk;

  cpu_core dut (
    .clk           (clk),
    .res           (res),
    .db_addr       (db_addr),
    .db_dataOut    (db_dataOut),
    .db_dataIn     (db_dataIn),
    .db_accessType (db_accessType),
    .db_ready      (db_ready)
  );

  // ---------------- shared state ----------------
  int checks   = 0;
  int failures = 0;

  logic [65:0] exp_q[$];           // {type, addr, wdata-or-0}
  logic [31:0] mem     [0:511];    // memory seen by the DUT
  logic [31:0] ref_mem [0:511];
  logic [31:0] ref_regs[32];
  logic [31:0] ref_pc;

  logic [31:0] fetch_log[$];
  int          w_count, w_cyc, stall_cnt, cyc;
  logic [31:0] w_addr, w_data;
  logic        fetched_18;

  int          ready_mode = 0;     // 0 always, 1 random, 2 directed stalls, 3 block W
  int          stall_left = 0;
  logic        x_arm = 1'b0, w_arm = 1'b0;

  logic        xfer_pending = 1'b0;
  logic [1:0]  xfer_type;
  logic [31:0] xfer_addr, xfer_data;
  logic        prev_stalled = 1'b0;
  logic [65:0] prev_req, obs, exp_v;

  logic [5:0]  fn_tab [0:5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};

  // ---------------- encoders ----------------
  function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] d,
                                        input logic [4:0] s, input logic [4:0] t);
    return {6'h00, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  function automatic logic [31:0] j_ins(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  // ---------------- reference model (instruction level) ----------------
  task automatic ref_run(input int steps);
    logic [31:0] ir, a, b, imm, ea, nxt;
    logic [5:0]  op, fn;
    logic [4:0]  s, t, d;
    for (int n = 0; n < steps; n++) begin
      exp_q.push_back({A_X, ref_pc, 32'h0});
      ir  = ref_mem[ref_pc[10:2]];
      op  = ir[31:26]; s = ir[25:21]; t = ir[20:16]; d = ir[15:11]; fn = ir[5:0];
      a   = ref_regs[s];
      b   = ref_regs[t];
      imm = {{16{ir[15]}}, ir[15:0]};
      nxt = ref_pc + 32'd4;
      case (op)
        6'h00: case (fn)
          6'h20: ref_regs[d] = a + b;
          6'h22: ref_regs[d] = a - b;
          6'h24: ref_regs[d] = a & b;
          6'h25: ref_regs[d] = a | b;
          6'h2A: ref_regs[d] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: ;
        endcase
        6'h08: ref_regs[t] = a + imm;
        6'h23: begin
          ea = (a + imm) & 32'hFFFF_FFFC;
          exp_q.push_back({A_R, ea, 32'h0});
          ref_regs[t] = ref_mem[ea[10:2]];
        end
        6'h2B: begin
          ea = (a + imm) & 32'hFFFF_FFFC;
          exp_q.push_back({A_W, ea, b});
          ref_mem[ea[10:2]] = b;
        end
        6'h04: if (a == b) nxt = nxt + (imm << 2);
        6'h05: if (a != b) nxt = nxt + (imm << 2);
        6'h02: nxt = {nxt[31:28], ir[25:0], 2'b00};
        default: ;
      endcase
      ref_regs[0] = 32'd0;
      ref_pc = nxt;
    end
  endtask

  // ---------------- driver: memory responses and db_ready ----------------
  always @(posedge clk) begin
    #1;
    if (xfer_pending) begin
      if (xfer_type == A_W) mem[xfer_addr[10:2]] = xfer_data;
      else                  db_dataIn = mem[xfer_addr[10:2]];
    end
    case (ready_mode)
      0: db_ready = 1'b1;
      1: db_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (stall_left > 0) begin
          db_ready = 1'b0;
          stall_left--;
        end else if (x_arm && db_accessType == A_X && db_addr == 32'h8) begin
          x_arm = 1'b0; db_ready = 1'b0; stall_left = 2;
        end else if (w_arm && db_accessType == A_W) begin
          w_arm = 1'b0; db_ready = 1'b0; stall_left = 2;
        end else begin
          db_ready = 1'b1;
        end
      end
      default: db_ready = (db_accessType != A_W);
    endcase
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    xfer_pending = 1'b0;
    if (!res) begin
      cyc++;
      obs = {db_accessType, db_addr, (db_accessType == A_W) ? db_dataOut : 32'h0};
      if (prev_stalled) begin
        checks++;
        if (obs !== prev_req) begin
          failures++;
          $display("FAIL hold_stable: got %h want %h", obs, prev_req);
        end
      end
      if (db_accessType != A_NONE && db_ready) begin
        xfer_pending = 1'b1;
        xfer_type    = db_accessType;
        xfer_addr    = db_addr;
        xfer_data    = db_dataOut;
        if (db_accessType == A_X) begin
          fetch_log.push_back(db_addr);
          if (db_addr == 32'h18) fetched_18 = 1'b1;
        end
        if (db_accessType == A_W) begin
          w_count++; w_addr = db_addr; w_data = db_dataOut; w_cyc = cyc;
        end
        if (exp_q.size() > 0) begin
          exp_v = exp_q.pop_front();
          checks++;
          if (obs !== exp_v) begin
            failures++;
            $display("FAIL bus_xfer: got type=%0d addr=%h data=%h want type=%0d addr=%h data=%h",
                     obs[65:64], obs[63:32], obs[31:0], exp_v[65:64], exp_v[63:32], exp_v[31:0]);
          end
        end
      end
      if (db_accessType != A_NONE && !db_ready) stall_cnt++;
      prev_stalled = (db_accessType != A_NONE) && !db_ready;
      prev_req     = obs;
    end else begin
      prev_stalled = 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = 32'd0;
  endtask

  task automatic begin_reset();
    @(posedge clk); #2;
    res = 1'b1;
    exp_q.delete();
    fetch_log.delete();
    w_count = 0; w_cyc = -1; stall_cnt = 0; cyc = -1;
    w_addr = 32'd0; w_data = 32'd0; fetched_18 = 1'b0;
    stall_left = 0;
  endtask

  // releases reset after building expectations, then checks the reset outputs
  task automatic end_reset(input int steps);
    for (int i = 0; i < 512; i++) ref_mem[i] = mem[i];
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
    ref_pc = 32'd0;
    ref_run(steps);
    @(posedge clk); #2;
    res = 1'b0;
    @(negedge clk);
    check_eq("rst_type", {30'd0, db_accessType}, {30'd0, A_NONE});
    check_eq("rst_addr", db_addr, 32'd0);
    check_eq("rst_dout", db_dataOut, 32'd0);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d transfers outstanding want 0", name, exp_q.size());
    end
  endtask

  task automatic load_sum_prog();
    clear_mem();
    mem[0] = i_ins(6'h08, 5'd0, 5'd1, 16'd64);   // addi $1,$0,64
    mem[1] = i_ins(6'h23, 5'd1, 5'd2, 16'd0);    // lw $2,0($1)
    mem[2] = i_ins(6'h23, 5'd1, 5'd3, 16'd4);    // lw $3,4($1)
    mem[3] = r_ins(6'h20, 5'd2, 5'd2, 5'd3);     // add $2,$2,$3
    mem[4] = i_ins(6'h23, 5'd1, 5'd3, 16'd8);    // lw $3,8($1)
    mem[5] = i_ins(6'h04, 5'd2, 5'd3, 16'd1);    // beq $2,$3,1
    mem[6] = i_ins(6'h2B, 5'd1, 5'd0, 16'd12);   // sw $0,12($1)
    mem[7] = i_ins(6'h2B, 5'd1, 5'd2, 16'd12);   // sw $2,12($1)
    mem[8] = j_ins(26'd8);                       // j 0x20 (self)
    mem[16] = 32'd4; mem[17] = 32'd5; mem[18] = 32'd9;
  endtask

  task automatic check_sum_results(input string tag, input int want_wcyc);
    check_eq({tag, "_wcount"}, w_count, 32'd1);
    check_eq({tag, "_waddr"},  w_addr, 32'h4C);
    check_eq({tag, "_wdata"},  w_data, 32'd9);
    check_eq({tag, "_mem4c"},  mem[19], 32'd9);
    check_eq({tag, "_no_fetch18"}, {31'd0, fetched_18}, 32'd0);
    check_eq({tag, "_wcycle"}, w_cyc, want_wcyc);
  endtask

  task automatic gen_random_prog();
    int k;
    logic [4:0] r1, r2, r3;
    clear_mem();
    for (int i = 0; i < 40; i++) begin
      k  = $urandom_range(0, 9);
      r1 = 5'($urandom_range(0, 7));
      r2 = 5'($urandom_range(0, 7));
      r3 = 5'($urandom_range(0, 7));
      case (k)
        0, 1, 2: mem[i] = r_ins(fn_tab[$urandom_range(0, 5)], r3, r1, r2);
        3, 4:    mem[i] = i_ins(6'h08, r1, r2, 16'($urandom));
        5:       mem[i] = i_ins(6'h23, 5'd0, r2, 16'(32'h400 + 4 * $urandom_range(0, 31)));
        6, 9:    mem[i] = i_ins(6'h2B, 5'd0, r2, 16'(32'h400 + 4 * $urandom_range(0, 31)));
        7:       mem[i] = i_ins(($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05, r1, r2,
                                16'($urandom_range(0, 3)));
        default: mem[i] = i_ins(6'h0F, r1, r2, 16'($urandom));   // undefined: NOP
      endcase
    end
    for (int i = 40; i < 44; i++) mem[i] = j_ins(26'(i));
    for (int i = 256; i < 288; i++) mem[i] = $urandom;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    // load-add-branch-store program with bus timing from reset
    ready_mode = 0;
    begin_reset();
    load_sum_prog();
    end_reset(8);
    @(negedge clk);
    check_eq("c1_type", {30'd0, db_accessType}, {30'd0, A_X});
    check_eq("c1_addr", db_addr, 32'h0);
    @(negedge clk);
    check_eq("c2_type", {30'd0, db_accessType}, {30'd0, A_NONE});
    @(negedge clk);
    check_eq("c3_type", {30'd0, db_accessType}, {30'd0, A_NONE});
    @(negedge clk);
    check_eq("c4_type", {30'd0, db_accessType}, {30'd0, A_X});
    check_eq("c4_addr", db_addr, 32'h4);
    wait_drain(300, "sum");
    check_sum_results("sum", 28);

    // same program with 3-cycle stalls on the fetch of 0x8 and on the store
    ready_mode = 2;
    begin_reset();
    load_sum_prog();
    x_arm = 1'b1; w_arm = 1'b1;
    end_reset(8);
    wait_drain(300, "stall");
    check_sum_results("stall", 34);
    check_eq("stall_cycles", stall_cnt, 32'd6);

    // $0 writes, sub/slt signedness, wrap-around
    ready_mode = 0;
    begin_reset();
    clear_mem();
    mem[0]  = i_ins(6'h08, 5'd0, 5'd0, 16'd5);        // addi $0,$0,5
    mem[1]  = r_ins(6'h20, 5'd4, 5'd0, 5'd0);         // add $4,$0,$0
    mem[2]  = i_ins(6'h2B, 5'd0, 5'd4, 16'h400);      // sw $4
    mem[3]  = i_ins(6'h08, 5'd0, 5'd5, 16'hFFFF);     // addi $5,$0,-1
    mem[4]  = i_ins(6'h08, 5'd0, 5'd6, 16'd1);        // addi $6,$0,1
    mem[5]  = r_ins(6'h22, 5'd7, 5'd5, 5'd6);         // sub $7,$5,$6
    mem[6]  = r_ins(6'h2A, 5'd8, 5'd5, 5'd6);         // slt $8,$5,$6
    mem[7]  = i_ins(6'h2B, 5'd0, 5'd7, 16'h404);
    mem[8]  = i_ins(6'h2B, 5'd0, 5'd8, 16'h408);
    mem[9]  = i_ins(6'h23, 5'd0, 5'd9, 16'h410);      // lw $9 = 0x7FFFFFFF
    mem[10] = r_ins(6'h20, 5'd11, 5'd9, 5'd6);        // add $11,$9,$6
    mem[11] = i_ins(6'h2B, 5'd0, 5'd11, 16'h40C);
    mem[12] = r_ins(6'h2A, 5'd12, 5'd6, 5'd5);        // slt $12,$6,$5
    mem[13] = i_ins(6'h2B, 5'd0, 5'd12, 16'h414);
    mem[14] = j_ins(26'd14);
    for (int i = 256; i < 262; i++) mem[i] = 32'hDEAD_BEEF;
    mem[260] = 32'h7FFF_FFFF;
    end_reset(15);
    wait_drain(300, "alu");
    check_eq("alu_zero_reg", mem[256], 32'd0);
    check_eq("alu_sub",      mem[257], 32'hFFFF_FFFE);
    check_eq("alu_slt_neg",  mem[258], 32'd1);
    check_eq("alu_wrap",     mem[259], 32'h8000_0000);
    check_eq("alu_slt_pos",  mem[261], 32'd0);

    // bne not taken, then jump
    begin_reset();
    clear_mem();
    mem[0]  = i_ins(6'h08, 5'd0, 5'd1, 16'd7);        // addi $1,$0,7
    mem[1]  = i_ins(6'h05, 5'd1, 5'd1, 16'd1);        // bne $1,$1,1
    mem[2]  = j_ins(26'h10);                          // j 0x10 -> 0x40
    mem[3]  = i_ins(6'h08, 5'd0, 5'd2, 16'd1);
    mem[16] = j_ins(26'h10);
    end_reset(4);
    wait_drain(100, "br");
    if (fetch_log.size() >= 4) begin
      check_eq("bne_next", fetch_log[2], 32'h8);
      check_eq("j_target", fetch_log[3], 32'h40);
    end else begin
      check_eq("br_fetch_count", fetch_log.size(), 32'd4);
    end

    // randomized programs with random and no back-pressure
    for (int t = 0; t < 6; t++) begin
      ready_mode = (t < 4) ? 1 : 0;
      begin_reset();
      gen_random_prog();
      end_reset(60);
      wait_drain(2000, "rand");
    end

    // reset while a store is waiting for db_ready
    ready_mode = 3;
    begin_reset();
    clear_mem();
    mem[0]   = i_ins(6'h08, 5'd0, 5'd1, 16'd3);
    mem[1]   = i_ins(6'h2B, 5'd0, 5'd1, 16'h400);
    mem[2]   = j_ins(26'd2);
    mem[256] = 32'h0000_1234;
    end_reset(0);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (db_accessType == A_W) break;
    end
    check_eq("pre_rst_w", {30'd0, db_accessType}, {30'd0, A_W});
    @(posedge clk); #2;
    res = 1'b1;
    @(posedge clk); #2;
    res = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_type", {30'd0, db_accessType}, {30'd0, A_NONE});
    check_eq("mid_rst_addr", db_addr, 32'd0);
    @(negedge clk);
    check_eq("post_rst_type", {30'd0, db_accessType}, {30'd0, A_X});
    check_eq("post_rst_addr", db_addr, 32'd0);
    check_eq("rst_no_write", w_count, 32'd0);
    check_eq("rst_mem_kept", mem[256], 32'h0000_1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
